multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle CPU. It replaces the single-cycle control LUT with a
//  FETCH/DECODE/EXEC/MEM/WB sequencer and drives the datapath enables and mux selects:
//  IR, PC, regfile, ALU and shared memory port.
//  Upstream of the datapath: it consumes the latched instruction fields and the ALU zero flag.
//  It also provides a memory-ack watchdog and a retired-instruction counter.
// PARAMETERS
//  TIMEOUT   16  max cycles mem_req may wait for mem_ack before entering TRAP (>=1)
//  CNT_W     32  width of instr_retired counter
// PORTS
//  clk            in   1      system clock, all state updates on rising edge
//  reset          in   1      asynchronous, active-low (0 = in reset)
//  opcode         in   6      IR[31:26] (valid from DECODE onward)
//  funct          in   6      IR[5:0]
//  alu_zero       in   1      ALU zero flag, combinational, valid in EXEC
//  mem_ack        in   1      memory completes current access this cycle
//  mem_req        out  1      memory access request
//  mem_we         out  1      memory write enable (qualified by mem_req)
//  iord           out  1      mem address select: 0=PC, 1=ALU result
//  ir_we          out  1      instruction register load
//  pc_we          out  1      PC load
//  pc_src         out  2      0=PC+4, 1=branch target, 2=jump target, 3=rs
//  alu_src_b      out  1      0=rt data, 1=sign-extended imm16
//  alu_op         out  3      0 ADD,1 SUB,2 XOR,3 SLT
//  reg_we         out  1      regfile write enable
//  reg_dst        out  2      0=rd, 1=rt, 2=r31
//  wb_src         out  2      0=ALU result, 1=mem data, 2=PC (already PC+4)
//  trap           out  1      sticky: illegal opcode or memory timeout
//  state          out  3      FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7
//  instr_retired  out  CNT_W  count of completed instructions, wraps to 0
// BEHAVIOUR
//  Reset: state=FETCH, instr_retired=0, trap=0, watchdog=0.
//   All strobes (mem_req, mem_we, ir_we, pc_we, reg_we) are 0 and all selects are 0 while reset=0.
//   Reset mid-instruction abandons the instruction; no partial write may follow.
//  Strobes are decoded from state plus inputs (ir_we, pc_we and reg_we may be Mealy); state is registered.
//  FETCH: mem_req=1, iord=0. Strobes stay 0 until mem_ack.
//   On mem_ack: ir_we=1, pc_we=1, pc_src=0, next DECODE.
//   Zero-wait memory (ack in the first cycle) is legal.
//  DECODE: recognised opcodes are R=0x00 (funct 0x20 ADD, 0x22 SUB, 0x2A SLT, 0x08 JR),
//   LW=0x23, SW=0x2B, ADDI=0x08, XORI=0x0E, BEQ=0x04, BNE=0x05, J=0x02, JAL=0x03.
//   J:   pc_we=1, pc_src=2 -> FETCH.
//   JAL: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wb_src=2 -> FETCH.
//   JR:  pc_we=1, pc_src=3 -> FETCH.
//   Unrecognised opcode or funct -> TRAP. All others -> EXEC.
//  EXEC: R-type: alu_src_b=0, alu_op from funct -> WB.
//   ADDI/LW/SW: alu_src_b=1, ADD. XORI: alu_src_b=1, XOR. ADDI/XORI -> WB; LW/SW -> MEM.
//   BEQ/BNE: alu_src_b=0, SUB, pc_src=1; pc_we = alu_zero (BEQ) or !alu_zero (BNE) -> FETCH.
//  MEM: mem_req=1, iord=1, mem_we=1 for SW. Hold until mem_ack; then SW -> FETCH, LW -> WB.
//  WB: reg_we=1 for exactly one cycle.
//   reg_dst=0 for R-type, 1 otherwise. wb_src=1 for LW, 0 otherwise. -> FETCH.
//  CPI: J/JAL/JR 2, BEQ/BNE 3, R/ADDI/XORI/SW 4, LW 5 (zero-wait memory).
//  Retire: instr_retired += 1 on the cycle an instruction's final state exits to FETCH.
//   Wraps at 2^CNT_W-1 -> 0. Not incremented on TRAP.
//  Watchdog: counts cycles with mem_req=1 and mem_ack=0. Cleared on ack or when leaving the state.
//   If it reaches TIMEOUT -> TRAP; mem_req drops the next cycle.
//  TRAP: all strobes 0, trap=1, no exit except reset.
//  mem_ack while mem_req=0 is ignored. mem_ack and the timeout in the same cycle: ack wins.
// TESTING
//  1 ADD r3,r1,r2 (opcode 0,funct 0x20), ack every cycle
//    -> states 0,1,2,4,0; reg_we=1 in WB only, reg_dst=0; instr_retired 0->1.
//  2 LW, mem_ack delayed 3 cycles in both FETCH and MEM
//    -> mem_req held high 4 cycles each; iord=1 in MEM; wb_src=1; total 11 cycles.
//  3 BEQ with alu_zero=1, then BNE with alu_zero=1
//    -> pc_we=1,pc_src=1 for BEQ; pc_we=0 for BNE; each 3 cycles.
//  4 JAL 0x03 -> DECODE: pc_we=1,pc_src=2,reg_we=1,reg_dst=2,wb_src=2; back to FETCH.
//  5 opcode 0x3F -> TRAP, trap=1, strobes 0 for 20 cycles.
//    Also: mem_ack never returns, TIMEOUT=16 -> TRAP after 16 wait cycles.
//  6 reset=0 asserted in MEM of SW -> mem_req/mem_we drop immediately;
//    after release: FETCH, counter=0. Preload counter at 2^CNT_W-1, retire once -> 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control sequencer for the multi-cycle CPU: FETCH/DECODE/EXEC/MEM/WB with
// datapath strobes, a memory-ack watchdog and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_b,
  output logic [2:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_src,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_JR  = 6'h08;

  state_t           state_reg, state_next;
  logic [WD_W-1:0]  wd_reg, wd_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             retire;
  logic             is_r, r_legal, legal, wd_expired;

  assign is_r    = (opcode == OP_R);
  assign r_legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT) || (funct == FN_JR);
  assign legal   = (is_r && r_legal) || (opcode == OP_J) || (opcode == OP_JAL) ||
                   (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_ADDI) ||
                   (opcode == OP_XORI) || (opcode == OP_LW) || (opcode == OP_SW);
  // Ack is checked before this, so an ack on the final allowed cycle still wins.
  assign wd_expired = (wd_reg == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_FETCH;
      wd_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      wd_reg    <= wd_next;
      if (retire) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    wd_next    = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    alu_src_b  = 1'b0;
    alu_op     = 3'd0;
    reg_we     = 1'b0;
    reg_dst    = 2'd0;
    wb_src     = 2'd0;
    case (state_reg)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end else if (wd_expired) begin
          state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_next = S_TRAP;
        end else if (opcode == OP_J || opcode == OP_JAL) begin
          pc_we      = 1'b1;
          pc_src     = 2'd2;
          state_next = S_FETCH;
          retire     = 1'b1;
          if (opcode == OP_JAL) begin
            reg_we  = 1'b1;
            reg_dst = 2'd2;
            wb_src  = 2'd2;
          end
        end else if (is_r && funct == FN_JR) begin
          pc_we      = 1'b1;
          pc_src     = 2'd3;
          state_next = S_FETCH;
          retire     = 1'b1;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        state_next = S_WB;
        if (is_r) begin
          alu_op = (funct == FN_SUB) ? 3'd1 : (funct == FN_SLT) ? 3'd3 : 3'd0;
        end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
          alu_op     = 3'd1;
          pc_src     = 2'd1;
          pc_we      = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
          state_next = S_FETCH;
          retire     = 1'b1;
        end else begin
          alu_src_b = 1'b1;
          if (opcode == OP_XORI) alu_op = 3'd2;
          if (opcode == OP_LW || opcode == OP_SW) state_next = S_MEM;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OP_SW);
        if (mem_ack) begin
          if (opcode == OP_SW) begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end else begin
            state_next = S_WB;
          end
        end else if (wd_expired) begin
          state_next = S_TRAP;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = is_r ? 2'd0 : 2'd1;
        wb_src     = (opcode == OP_LW) ? 2'd1 : 2'd0;
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_TRAP;
    endcase
    if (mem_req && !mem_ack && state_next == state_reg) wd_next = wd_reg + WD_W'(1);
    // Outputs are forced idle while reset is held, independent of the clock.
    if (!reset) begin
      retire    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'd0;
      alu_src_b = 1'b0;
      alu_op    = 3'd0;
      reg_we    = 1'b0;
      reg_dst   = 2'd0;
      wb_src    = 2'd0;
    end
  end

  assign state         = state_reg;
  assign trap          = (state_reg == S_TRAP);
  assign instr_retired = cnt_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: expected per-cycle output traces are built
// from each instruction class's phase sequence and compared every cycle.
module tb_multicycle_ctrl;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode, funct;
  logic          alu_zero, mem_ack;
  logic          mem_req, mem_we, iord, ir_we, pc_we, alu_src_b, reg_we, trap;
  logic [1:0]    pc_src, reg_dst, wb_src;
  logic [2:0]    alu_op, state;
  logic [CW-1:0] instr_retired;
  logic [19:0]   obs;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  typedef struct {
    logic        ack;
    logic [19:0] v;
  } cyc_t;

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_we(reg_we), .reg_dst(reg_dst), .wb_src(wb_src), .trap(trap), .state(state),
    .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  assign obs = {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_b, alu_op,
                reg_we, reg_dst, wb_src, trap};

  function automatic logic [19:0] pk(int st, bit req, bit we, bit io, bit irw, bit pcw,
                                     int pcs, bit asb, int aop, bit rw, int rd, int wbs, bit tr);
    return {st[2:0], req, we, io, irw, pcw, pcs[1:0], asb, aop[2:0], rw, rd[1:0], wbs[1:0], tr};
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Expected trace: fetch (df wait cycles), decode, then class-specific phases.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int df, input int dm);
    cyc_t  q[$];
    string nm;
    bit    taken;
    for (int i = 0; i <= df; i++)
      q.push_back('{ack: (i == df), v: pk(0,1,0,0,i==df,i==df,0,0,0,0,0,0,0)});
    if (op == 6'h02 || op == 6'h03 || (op == 6'h00 && fn == 6'h08)) begin
      nm = (op == 6'h02) ? "J" : (op == 6'h03) ? "JAL" : "JR";
      if (op == 6'h03) q.push_back('{ack: 1'($urandom_range(0,1)), v: pk(1,0,0,0,0,1,2,0,0,1,2,2,0)});
      else q.push_back('{ack: 1'($urandom_range(0,1)),
                         v: pk(1,0,0,0,0,1,(op == 6'h02) ? 2 : 3,0,0,0,0,0,0)});
    end else begin
      q.push_back('{ack: 1'($urandom_range(0,1)), v: pk(1,0,0,0,0,0,0,0,0,0,0,0,0)});
      if (op == 6'h04 || op == 6'h05) begin
        nm    = (op == 6'h04) ? "BEQ" : "BNE";
        taken = (op == 6'h04) ? z : !z;
        q.push_back('{ack: 1'($urandom_range(0,1)), v: pk(2,0,0,0,0,taken,1,0,1,0,0,0,0)});
      end else if (op == 6'h00) begin
        nm = (fn == 6'h20) ? "ADD" : (fn == 6'h22) ? "SUB" : "SLT";
        q.push_back('{ack: 1'($urandom_range(0,1)),
                      v: pk(2,0,0,0,0,0,0,0,(fn == 6'h20) ? 0 : (fn == 6'h22) ? 1 : 3,0,0,0,0)});
        q.push_back('{ack: 1'($urandom_range(0,1)), v: pk(4,0,0,0,0,0,0,0,0,1,0,0,0)});
      end else if (op == 6'h08 || op == 6'h0E) begin
        nm = (op == 6'h08) ? "ADDI" : "XORI";
        q.push_back('{ack: 1'($urandom_range(0,1)),
                      v: pk(2,0,0,0,0,0,0,1,(op == 6'h08) ? 0 : 2,0,0,0,0)});
        q.push_back('{ack: 1'($urandom_range(0,1)), v: pk(4,0,0,0,0,0,0,0,0,1,1,0,0)});
      end else begin
        nm = (op == 6'h23) ? "LW" : "SW";
        q.push_back('{ack: 1'($urandom_range(0,1)), v: pk(2,0,0,0,0,0,0,1,0,0,0,0,0)});
        for (int i = 0; i <= dm; i++)
          q.push_back('{ack: (i == dm), v: pk(3,1,op == 6'h2B,1,0,0,0,0,0,0,0,0,0)});
        if (op == 6'h23) q.push_back('{ack: 1'($urandom_range(0,1)), v: pk(4,0,0,0,0,0,0,0,0,1,1,1,0)});
      end
    end
    opcode = op; funct = fn; alu_zero = z;
    for (int i = 0; i < q.size(); i++) begin
      mem_ack = q[i].ack;
      @(negedge clk);
      chk($sformatf("%s_cyc%0d", nm, i), obs, q[i].v);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk({nm, "_retired"}, instr_retired, exp_cnt);
    chk({nm, "_back_to_fetch"}, state, 0);
    $display("instr %-4s op=%h fn=%h z=%0d cycles=%0d retired=%0d", nm, op, fn, z, q.size(), instr_retired);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("reset_outputs", obs, 20'd0);
    @(posedge clk); #1;
    exp_cnt = 0;
    chk("reset_outputs_held", obs, 20'd0);
    chk("reset_counter", instr_retired, 0);
    reset = 1'b1;
  endtask

  task automatic run_random();
    int k;
    k = $urandom_range(0, 11);
    case (k)
      0:  run_instr(6'h00, 6'h20, 1'($urandom), $urandom_range(0,3), 0);
      1:  run_instr(6'h00, 6'h22, 1'($urandom), $urandom_range(0,3), 0);
      2:  run_instr(6'h00, 6'h2A, 1'($urandom), $urandom_range(0,3), 0);
      3:  run_instr(6'h00, 6'h08, 1'($urandom), $urandom_range(0,3), 0);
      4:  run_instr(6'h23, 6'($urandom), 1'($urandom), $urandom_range(0,3), $urandom_range(0,3));
      5:  run_instr(6'h2B, 6'($urandom), 1'($urandom), $urandom_range(0,3), $urandom_range(0,3));
      6:  run_instr(6'h08, 6'($urandom), 1'($urandom), $urandom_range(0,3), 0);
      7:  run_instr(6'h0E, 6'($urandom), 1'($urandom), $urandom_range(0,3), 0);
      8:  run_instr(6'h04, 6'($urandom), 1'($urandom), $urandom_range(0,3), 0);
      9:  run_instr(6'h05, 6'($urandom), 1'($urandom), $urandom_range(0,3), 0);
      10: run_instr(6'h02, 6'($urandom), 1'($urandom), $urandom_range(0,3), 0);
      default: run_instr(6'h03, 6'($urandom), 1'($urandom), $urandom_range(0,3), 0);
    endcase
  endtask

  initial begin
    reset = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ack = 1'b0;
    #1;
    chk("reset_outputs_t0", obs, 20'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_counter_t0", instr_retired, 0);
    reset = 1'b1;

    run_instr(6'h00, 6'h20, 1'b0, 0, 0);
    run_instr(6'h23, 6'h00, 1'b0, 3, 3);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);
    run_instr(6'h05, 6'h00, 1'b1, 0, 0);
    run_instr(6'h03, 6'h00, 1'b0, 0, 0);
    // Ack on the last cycle the watchdog allows is still a normal access.
    run_instr(6'h23, 6'h00, 1'b0, 15, 15);
    for (int n = 0; n < 40; n++) run_random();

    // Reset asserted while a store is in MEM.
    opcode = 6'h2B; funct = 6'h00; mem_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    @(negedge clk);
    chk("sw_mem_active", obs, pk(3,1,1,1,0,0,0,0,0,0,0,0,0));
    chk("sw_counter_nonzero", (instr_retired != 0), 1);
    reset = 1'b0;
    #1;
    chk("sw_reset_mem_req", mem_req, 0);
    chk("sw_reset_mem_we", mem_we, 0);
    @(posedge clk); #1;
    apply_reset();
    $display("instr SW   reset in MEM retired=%0d", instr_retired);

    // Illegal opcode: trap and stay with strobes idle.
    opcode = 6'h3F; mem_ack = 1'b1;
    @(negedge clk); chk("ill_fetch", obs, pk(0,1,0,0,1,1,0,0,0,0,0,0,0));
    @(posedge clk); #1;
    @(negedge clk); chk("ill_decode", obs, pk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      mem_ack = 1'($urandom_range(0,1));
      @(negedge clk); chk($sformatf("ill_trap%0d", i), obs, pk(7,0,0,0,0,0,0,0,0,0,0,0,1));
    end
    chk("ill_no_retire", instr_retired, exp_cnt);
    $display("instr ILL  op=3f trapped retired=%0d", instr_retired);
    @(posedge clk); #1;
    apply_reset();

    // Memory never acks: 16 wait cycles then trap.
    mem_ack = 1'b0; opcode = 6'h00; funct = 6'h20;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); chk($sformatf("to_wait%0d", i), obs, pk(0,1,0,0,0,0,0,0,0,0,0,0,0));
      @(posedge clk); #1;
    end
    @(negedge clk); chk("to_trap", obs, pk(7,0,0,0,0,0,0,0,0,0,0,0,1));
    $display("instr FETCH timeout trapped retired=%0d", instr_retired);
    @(posedge clk); #1;
    apply_reset();

    // Counter wrap: retire 2^CW instructions, landing back on zero.
    for (int n = 0; n < (1 << CW); n++) run_instr(6'h02, 6'h00, 1'b0, 0, 0);
    chk("wrap_zero", instr_retired, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
